bin_window_3x3: RTL and testbench
=================================

Name: bin_window_3x3

Overview:
- Consumes the binary test-image stream from the test-data buffer stage (vsync/hsync/valid/1-bit data/frame-done).
- Uses two line buffers to build a 3x3 sliding window of binary pixels over the 28x28 frame.
- Emits one window per output position, valid-convolution only (26x26 windows per frame), to the first binary conv stage.
- Adds frame-boundary tracking, output coordinates, a frame-done pulse and an overrun flag.

Parameters:
- IMG_W, 28, active pixels per row.
- IMG_H, 28, active rows per frame.
- CW, $clog2(IMG_W), column/row counter width (IMG_H <= 2**CW required).

Ports:
- i_sclk  in  1  clock, all logic rising-edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_vsync  in  1  frame sync; a rising edge marks frame start.
- i_hsync  in  1  line sync; informational only, ignored by the datapath.
- i_valid  in  1  pixel qualifier.
- i_tdata  in  1  binary pixel, sampled when i_valid=1.
- i_vdone  in  1  upstream frame-end pulse.
- o_win  out  9  window; bit 3*r+c, r=0 is the row two lines back, c=0 is the column two pixels back; bit 8 is the newest pixel.
- o_win_valid  out  1  window qualifier, single-cycle per window.
- o_row  out  CW  output row index 0..IMG_H-3 (top-left of window).
- o_col  out  CW  output col index 0..IMG_W-3.
- o_frame_done  out  1  one-cycle pulse with the last window of a frame.
- o_overrun  out  1  sticky flag: more than IMG_W*IMG_H pixels arrived in a frame.

Behaviour:
- Reset (async, i_rstn=0): all outputs 0, counters 0, line buffers and window registers cleared, frame state IDLE.
- Frame states:
  - IDLE: waiting for frame start.
  - ACTIVE: accepting pixels.
  - DONE: IMG_W*IMG_H pixels accepted; further valids are ignored.
- Transitions:
  - Any state -> ACTIVE on an i_vsync rising edge (edge detected against a registered copy). This clears the counters and o_overrun; line-buffer contents need not be cleared.
  - ACTIVE -> DONE after the pixel at (IMG_H-1, IMG_W-1) is accepted.
  - DONE/ACTIVE -> IDLE on i_vdone.
  - If i_vsync rising edge and i_vdone occur in the same cycle, vsync wins.
- Accept condition: i_valid=1 and state ACTIVE.
  - Each accepted pixel shifts the window left one column and loads the new column {lb2_tap, lb1_tap, i_tdata} (top..bottom).
  - lb1 and lb2 each shift by one.
- Counters: col_in increments per accepted pixel and wraps IMG_W-1 -> 0, incrementing row_in.
- Gaps in i_valid mid-row are tolerated; only accepted beats count.
- Window output: when an accepted pixel has row_in>=2 and col_in>=2, the next cycle asserts o_win_valid=1 with:
  - o_win = the updated window;
  - o_row = row_in-2, o_col = col_in-2.
- Latency: 1 cycle from the completing input pixel to o_win_valid.
- Windows never straddle a row wrap; col_in<2 suppresses output.
- o_frame_done: asserted in the same cycle as the window with o_row=IMG_H-3 and o_col=IMG_W-3.
- o_overrun: set on i_valid=1 while in DONE. It holds until the next vsync rising edge or reset.
- i_valid in IDLE is ignored and does not set o_overrun.
- o_win and o_row/o_col hold their last values when o_win_valid=0.
- Mid-frame vsync restarts the frame; a partial frame produces no o_frame_done.

Optional Feature:
- WIN_POPCOUNT_EN defined:
  - Adds output o_popcnt [3:0], the count of ones in the window.
  - Registered alongside o_win, so it has the same latency and qualification; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package bin_window_pkg holds:
  - IMG_W/IMG_H defaults;
  - the window-bit index constants (WIN_TL=0, WIN_CENTER=4, WIN_BR=8);
  - the frame-state enum (IDLE, ACTIVE, DONE).
- One sub-module, bin_line_buffer: a depth-IMG_W 1-bit shift register with shift enable and output tap. It is instantiated twice.

Test Plan:
- All-ones frame (784 valid pixels) -> exactly 676 o_win_valid pulses, each with o_win=9'h1FF. o_frame_done is asserted once with o_row=25, o_col=25.
- Single 1 at pixel (10,10), rest 0 -> exactly 9 windows are nonzero:
  - at (8,8), o_win=9'h100;
  - at (10,10), o_win=9'h001;
  - at (9,9), o_win=9'h010.
- Row-gapped stream (i_valid low 5 cycles between rows, and 2 cycles inside row 3) -> same window sequence as the gapless stream; coordinates stay continuous.
- 800 valid pixels in one frame -> o_overrun=1 after pixel 785 and holds until the next vsync edge. Window count stays 676.
- vsync rising edge after row 12, then a full frame -> the first frame gives no o_frame_done; the second frame yields 676 windows starting at (0,0).
- Async reset asserted mid-row 15 -> all outputs 0 immediately. After release and a new vsync, the full frame is processed correctly. With WIN_POPCOUNT_EN, the all-ones frame gives o_popcnt=9.

Source files
------------

// File: rtl/bin_window_pkg.sv
// bin_window_pkg
//   Shared definitions for the 3x3 binary window builder: default frame
//   geometry, window bit positions, the frame-state type and a small
//   popcount helper for the optional popcount output.
package bin_window_pkg;

  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;

  // Window bit index = 3*row + col; row 0 is the oldest line, col 0 the
  // oldest pixel, so bit 8 is always the newest pixel.
  localparam int WIN_TL     = 0;
  localparam int WIN_CENTER = 4;
  localparam int WIN_BR     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } frame_state_t;

  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 9; i++) begin
      sum = sum + {3'b000, v[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/bin_window_line_buffer.sv
// bin_line_buffer
//   1-bit shift register of DEPTH stages used as a line delay. On each
//   shift the oldest bit leaves through tap (read before the shift, i.e.
//   tap is the value that entered DEPTH shifts ago).
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset, clears the contents
//   shift  - advance the line by one pixel
//   din    - pixel entering the line
//   tap    - pixel that entered DEPTH shifts earlier
module bin_line_buffer #(
  parameter int DEPTH = 28
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift,
  input  logic din,
  output logic tap
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (shift) begin
      sr <= {sr[DEPTH-2:0], din};
    end
  end

  assign tap = sr[DEPTH-1];

endmodule

// File: rtl/bin_window_3x3.sv
// bin_window_3x3
//   Builds a 3x3 sliding window of binary pixels over an IMG_W x IMG_H
//   frame using two line buffers and emits only fully-inside (valid
//   convolution) windows, with output coordinates, a frame-done pulse and
//   a sticky overrun flag.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a vsync rising edge
//   ACTIVE | accepting pixels of the current frame
//   DONE   | full frame accepted; further valids only raise o_overrun
//
// Ports:
//   i_sclk, i_rstn        clock / asynchronous active-low reset
//   i_vsync               frame sync, rising edge starts a frame
//   i_hsync               line sync, informational only
//   i_valid, i_tdata      pixel qualifier and 1-bit pixel
//   i_vdone               upstream frame-end pulse
//   o_win, o_win_valid    window (bit 3*r+c) and its single-cycle qualifier
//   o_row, o_col          top-left coordinate of the emitted window
//   o_frame_done          pulse with the last window of a frame
//   o_overrun             sticky: pixels arrived after the frame was full
//   o_popcnt              ones in the window (only with WIN_POPCOUNT_EN)
//
// Build option: define WIN_POPCOUNT_EN to add the o_popcnt output.
module bin_window_3x3
  import bin_window_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int CW    = $clog2(IMG_W)
) (
  input  logic          i_sclk,
  input  logic          i_rstn,
  input  logic          i_vsync,
  input  logic          i_hsync,
  input  logic          i_valid,
  input  logic          i_tdata,
  input  logic          i_vdone,
  output logic [8:0]    o_win,
  output logic          o_win_valid,
  output logic [CW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_frame_done,
  output logic          o_overrun
`ifdef WIN_POPCOUNT_EN
  ,output logic [3:0]   o_popcnt
`endif
);

  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [CW-1:0] C_TWO    = CW'(2);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);

  frame_state_t  state;
  logic          vsync_q;
  logic          vsync_rise;
  logic          accept;
  logic [CW-1:0] col_in;
  logic [CW-1:0] row_in;
  logic [8:0]    win;
  logic [8:0]    win_next;
  logic          lb1_tap;
  logic          lb2_tap;
  logic          last_pix;
  logic          emit;

  // hsync carries no information the datapath needs
  logic unused_hsync;
  assign unused_hsync = i_hsync;

  assign vsync_rise = i_vsync & ~vsync_q;
  // A restarting vsync discards any pixel presented in the same cycle.
  assign accept     = i_valid & (state == ACTIVE) & ~vsync_rise;
  assign last_pix   = (row_in == ROW_LAST) && (col_in == COL_LAST);
  assign emit       = (row_in >= C_TWO) && (col_in >= C_TWO);

  // Each row shifts left; the new right-hand column is {lb2, lb1, pixel}.
  assign win_next = {i_tdata, win[8:7], lb1_tap, win[5:4], lb2_tap, win[2:1]};

  bin_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
    .clk   (i_sclk),
    .rst_n (i_rstn),
    .shift (accept),
    .din   (i_tdata),
    .tap   (lb1_tap)
  );

  bin_line_buffer #(.DEPTH(IMG_W)) u_lb2 (
    .clk   (i_sclk),
    .rst_n (i_rstn),
    .shift (accept),
    .din   (lb1_tap),
    .tap   (lb2_tap)
  );

  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= IDLE;
      vsync_q      <= 1'b0;
      col_in       <= '0;
      row_in       <= '0;
      win          <= '0;
      o_win        <= '0;
      o_win_valid  <= 1'b0;
      o_row        <= '0;
      o_col        <= '0;
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
`ifdef WIN_POPCOUNT_EN
      o_popcnt     <= '0;
`endif
    end else begin
      vsync_q      <= i_vsync;
      o_win_valid  <= 1'b0;
      o_frame_done <= 1'b0;

      if (vsync_rise) begin
        state     <= ACTIVE;
        col_in    <= '0;
        row_in    <= '0;
        o_overrun <= 1'b0;
      end else begin
        if (accept) begin
          win <= win_next;
          if (col_in == COL_LAST) begin
            col_in <= '0;
            row_in <= row_in + C_ONE;
          end else begin
            col_in <= col_in + C_ONE;
          end
          if (emit) begin
            o_win_valid <= 1'b1;
            o_win       <= win_next;
            o_row       <= row_in - C_TWO;
            o_col       <= col_in - C_TWO;
`ifdef WIN_POPCOUNT_EN
            o_popcnt    <= popcount9(win_next);
`endif
          end
          if (last_pix) begin
            state        <= DONE;
            row_in       <= '0;
            o_frame_done <= 1'b1;
          end
        end
        if (i_valid && state == DONE) begin
          o_overrun <= 1'b1;
        end
        // vdone overrides an ACTIVE->DONE step taken in the same cycle
        if (i_vdone && state != IDLE) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin_window_3x3.sv
module tb_bin_window_3x3;
  localparam int W  = 28;
  localparam int H  = 28;
  localparam int CW = 5;
  localparam int NWIN = (W - 2) * (H - 2);

  logic          i_sclk = 1'b0;
  logic          i_rstn;
  logic          i_vsync;
  logic          i_hsync;
  logic          i_valid;
  logic          i_tdata;
  logic          i_vdone;
  logic [8:0]    o_win;
  logic          o_win_valid;
  logic [CW-1:0] o_row;
  logic [CW-1:0] o_col;
  logic          o_frame_done;
  logic          o_overrun;
`ifdef WIN_POPCOUNT_EN
  logic [3:0]    o_popcnt;
`endif

  bin_window_3x3 dut (
    .i_sclk       (i_sclk),
    .i_rstn       (i_rstn),
    .i_vsync      (i_vsync),
    .i_hsync      (i_hsync),
    .i_valid      (i_valid),
    .i_tdata      (i_tdata),
    .i_vdone      (i_vdone),
    .o_win        (o_win),
    .o_win_valid  (o_win_valid),
    .o_row        (o_row),
    .o_col        (o_col),
    .o_frame_done (o_frame_done),
    .o_overrun    (o_overrun)
`ifdef WIN_POPCOUNT_EN
    ,.o_popcnt    (o_popcnt)
`endif
  );

  always #5 i_sclk = ~i_sclk;

  typedef struct {
    logic [8:0]    win;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          done;
  } exp_t;

  exp_t          exp_q[$];
  bit            img[H][W];
  int            total = 0;
  int            passed = 0;
  int            win_cnt = 0;
  int            nz_cnt = 0;
  int            done_cnt = 0;
  logic [CW-1:0] done_row;
  logic [CW-1:0] done_col;

  function automatic exp_t model_win(input int r, input int c);
    exp_t e;
    e.win = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        e.win[3*rr+cc] = img[r-2+rr][c-2+cc];
    e.row  = CW'(r - 2);
    e.col  = CW'(c - 2);
    e.done = (r == H - 1) && (c == W - 1);
    return e;
  endfunction

  // Output monitor / scoreboard consumer, sampled mid-cycle.
  always @(negedge i_sclk) begin
    if (i_rstn === 1'b1 && o_win_valid === 1'b1) begin
      exp_t e;
      win_cnt++;
      if (o_win != 9'd0) nz_cnt++;
      if (o_frame_done === 1'b1) begin
        done_cnt++;
        done_row = o_row;
        done_col = o_col;
      end
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_window: got win=%h row=%0d col=%0d, required no window", o_win, o_row, o_col);
      end else begin
        e = exp_q.pop_front();
        if (o_win !== e.win || o_row !== e.row || o_col !== e.col || o_frame_done !== e.done) begin
          $display("FAIL window: got win=%h row=%0d col=%0d done=%b, required win=%h row=%0d col=%0d done=%b",
                   o_win, o_row, o_col, o_frame_done, e.win, e.row, e.col, e.done);
        end else begin
`ifdef WIN_POPCOUNT_EN
          if (o_popcnt !== 4'($countones(e.win)))
            $display("FAIL popcnt: got %0d, required %0d", o_popcnt, $countones(e.win));
          else
            passed++;
`else
          passed++;
`endif
        end
      end
    end else if (i_rstn === 1'b1 && o_frame_done === 1'b1) begin
      total++;
      $display("FAIL frame_done_without_window: got frame_done=1 with win_valid=0, required 0");
    end
  end

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_hsync = 1'b0;
    repeat (n) begin
      @(posedge i_sclk);
      #1;
    end
  endtask

  task automatic send_pixel(input int k);
    int r, c;
    r = k / W;
    c = k % W;
    i_valid = 1'b1;
    i_hsync = 1'b1;
    if (k < W * H) begin
      i_tdata = img[r][c];
      if (r >= 2 && c >= 2) exp_q.push_back(model_win(r, c));
    end else begin
      i_tdata = 1'($urandom_range(0, 1));
    end
    @(posedge i_sclk);
    #1;
  endtask

  task automatic start_frame();
    i_vsync = 1'b1;
    idle(1);
    i_vsync = 1'b0;
  endtask

  task automatic end_frame();
    idle(4);
    i_vdone = 1'b1;
    idle(1);
    i_vdone = 1'b0;
    idle(2);
  endtask

  task automatic drive_frame(input int npix, input bit gapped);
    for (int k = 0; k < npix; k++) begin
      if (gapped && k > 0 && k % W == 0) idle(5);
      if (gapped && k == 3 * W + 10) idle(2);
      send_pixel(k);
    end
    i_valid = 1'b0;
  endtask

  task automatic clear_counts();
    win_cnt  = 0;
    nz_cnt   = 0;
    done_cnt = 0;
    done_row = '0;
    done_col = '0;
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_vsync = 1'b0; i_hsync = 1'b0;
    i_valid = 1'b0; i_tdata = 1'b0; i_vdone = 1'b0;
    #23;
    total++; if (o_win_valid !== 1'b0) $display("FAIL reset_win_valid: got %b, required 0", o_win_valid); else passed++;
    total++; if (o_win !== 9'd0) $display("FAIL reset_win: got %h, required 000", o_win); else passed++;
    total++; if (o_frame_done !== 1'b0 || o_overrun !== 1'b0) $display("FAIL reset_flags: got done=%b ovr=%b, required 0 0", o_frame_done, o_overrun); else passed++;
    total++; if (o_row !== '0 || o_col !== '0) $display("FAIL reset_coords: got row=%0d col=%0d, required 0 0", o_row, o_col); else passed++;
    i_rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_all_ones();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 1'b1;
    clear_counts();
    start_frame();
    drive_frame(W * H, 1'b0);
    end_frame();
    total++; if (win_cnt !== NWIN) $display("FAIL ones_count: got %0d windows, required %0d", win_cnt, NWIN); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL ones_done_count: got %0d, required 1", done_cnt); else passed++;
    total++; if (done_row !== CW'(25) || done_col !== CW'(25)) $display("FAIL ones_done_coord: got row=%0d col=%0d, required 25 25", done_row, done_col); else passed++;
    total++; if (exp_q.size() !== 0) $display("FAIL ones_leftover: got %0d pending, required 0", exp_q.size()); else passed++;
  endtask

  task automatic test_idle_ignored();
    // previous frame ended with vdone, so the block is idle
    clear_counts();
    for (int k = 0; k < 10; k++) begin
      i_valid = 1'b1;
      i_tdata = 1'b1;
      @(posedge i_sclk);
      #1;
    end
    idle(3);
    total++; if (win_cnt !== 0) $display("FAIL idle_windows: got %0d, required 0", win_cnt); else passed++;
    total++; if (o_overrun !== 1'b0) $display("FAIL idle_overrun: got %b, required 0", o_overrun); else passed++;
  endtask

  task automatic test_single_one();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 1'b0;
    img[10][10] = 1'b1;
    clear_counts();
    start_frame();
    drive_frame(W * H, 1'b0);
    end_frame();
    total++; if (nz_cnt !== 9) $display("FAIL single_nonzero: got %0d nonzero windows, required 9", nz_cnt); else passed++;
    total++; if (win_cnt !== NWIN) $display("FAIL single_count: got %0d, required %0d", win_cnt, NWIN); else passed++;
  endtask

  task automatic test_gapped();
    fill_random();
    clear_counts();
    start_frame();
    drive_frame(W * H, 1'b1);
    end_frame();
    total++; if (win_cnt !== NWIN) $display("FAIL gapped_count: got %0d, required %0d", win_cnt, NWIN); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL gapped_done: got %0d, required 1", done_cnt); else passed++;
  endtask

  task automatic test_overrun();
    fill_random();
    clear_counts();
    start_frame();
    for (int k = 0; k < 800; k++) begin
      send_pixel(k);
      if (k == W * H - 1) begin
        total++; if (o_overrun !== 1'b0) $display("FAIL overrun_early: got %b after pixel 784, required 0", o_overrun); else passed++;
      end
      if (k == W * H) begin
        total++; if (o_overrun !== 1'b1) $display("FAIL overrun_set: got %b after pixel 785, required 1", o_overrun); else passed++;
      end
    end
    idle(3);
    total++; if (o_overrun !== 1'b1) $display("FAIL overrun_hold: got %b, required 1", o_overrun); else passed++;
    total++; if (win_cnt !== NWIN) $display("FAIL overrun_count: got %0d, required %0d", win_cnt, NWIN); else passed++;
    end_frame();
    total++; if (o_overrun !== 1'b1) $display("FAIL overrun_vdone_hold: got %b, required 1", o_overrun); else passed++;
    start_frame();
    total++; if (o_overrun !== 1'b0) $display("FAIL overrun_clear: got %b after vsync, required 0", o_overrun); else passed++;
    end_frame();
  endtask

  task automatic test_restart();
    fill_random();
    clear_counts();
    start_frame();
    drive_frame(13 * W, 1'b0);
    idle(2);
    total++; if (done_cnt !== 0) $display("FAIL restart_partial_done: got %0d, required 0", done_cnt); else passed++;
    start_frame();
    drive_frame(W * H, 1'b0);
    end_frame();
    total++; if (win_cnt !== 11 * (W - 2) + NWIN) $display("FAIL restart_count: got %0d, required %0d", win_cnt, 11 * (W - 2) + NWIN); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL restart_done: got %0d, required 1", done_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    fill_random();
    clear_counts();
    start_frame();
    drive_frame(15 * W + 7, 1'b0);
    #2;
    i_rstn = 1'b0;
    #1;
    total++; if (o_win_valid !== 1'b0 || o_frame_done !== 1'b0 || o_overrun !== 1'b0) $display("FAIL midreset_flags: got v=%b d=%b o=%b, required 0 0 0", o_win_valid, o_frame_done, o_overrun); else passed++;
    total++; if (o_win !== 9'd0) $display("FAIL midreset_win: got %h, required 000", o_win); else passed++;
    total++; if (o_row !== '0 || o_col !== '0) $display("FAIL midreset_coords: got row=%0d col=%0d, required 0 0", o_row, o_col); else passed++;
`ifdef WIN_POPCOUNT_EN
    total++; if (o_popcnt !== 4'd0) $display("FAIL midreset_popcnt: got %0d, required 0", o_popcnt); else passed++;
`endif
    exp_q.delete();
    #10;
    i_rstn = 1'b1;
    idle(2);
    clear_counts();
    start_frame();
    drive_frame(W * H, 1'b0);
    end_frame();
    total++; if (win_cnt !== NWIN) $display("FAIL midreset_count: got %0d, required %0d", win_cnt, NWIN); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL midreset_done: got %0d, required 1", done_cnt); else passed++;
    total++; if (exp_q.size() !== 0) $display("FAIL midreset_leftover: got %0d pending, required 0", exp_q.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_idle_ignored();
    test_single_one();
    test_gapped();
    test_overrun();
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
